// File: rtl/handler_pkg.sv
// Shared definitions for the GAScore handler packet filter.
// Header field positions, word width and filter FSM states.
`timescale 1ns/1ps
package handler_pkg;

    localparam int WORD_W      = 64;
    localparam int DST_MSB     = 39;
    localparam int DST_LSB     = 24;
    localparam int HANDLER_MSB = 55;
    localparam int HANDLER_LSB = 52;

    typedef enum logic [1:0] {
        ST_HEADER,
        ST_STORE,
        ST_DROP
    } handler_filter_state_t;

    // Saturating increment for the 16-bit drop counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/handler_pkt_ram.sv
// Packet buffer: one write port, one asynchronous read port.
// Kept standalone so it maps onto distributed/LUT RAM.
`timescale 1ns/1ps
module handler_pkt_ram
    import handler_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W:0]   wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W:0]   rdata
);

    logic [WORD_W:0] mem [DEPTH];

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/handler_pkt_filter.sv
// Store-and-forward filter in front of the handler wrapper.
// Releases only whole packets whose destination is a local kernel.
`timescale 1ns/1ps
module handler_pkt_filter
    import handler_pkg::*;
#(
    parameter int NUM_KERNELS = 2,
    parameter int DEPTH       = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [63:0] axis_in_tdata,
    input  logic        axis_in_tlast,
    input  logic        axis_in_tvalid,
    output logic        axis_in_tready,
    input  logic [15:0] address_offset,
    output logic [63:0] axis_handler_tdata,
    output logic        axis_handler_tlast,
    output logic        axis_handler_tvalid,
    input  logic        axis_handler_tready,
    output logic [15:0] drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    handler_filter_state_t state;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] commit_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] pkt_len;

    logic [15:0]   dst_rel;
    logic          hdr_ok;
    logic          full;
    logic          oversize;
    logic          in_hs;
    logic          out_hs;
    logic          we;
    logic [WORD_W:0] rdata;

    // Wrapping subtraction: destinations below the offset become huge.
    assign dst_rel  = axis_in_tdata[DST_MSB:DST_LSB] - address_offset;
    assign hdr_ok   = dst_rel < 16'(NUM_KERNELS);

    assign full     = (wr_ptr - rd_ptr) == DEPTH_P;
    assign oversize = (state == ST_STORE) && (pkt_len == DEPTH_P);

    // Discarding states never stall, so a full buffer cannot deadlock.
    assign axis_in_tready = reset_n &&
        ((state == ST_DROP) || oversize || !full);

    assign in_hs  = axis_in_tvalid && axis_in_tready;
    assign out_hs = axis_handler_tvalid && axis_handler_tready;

    assign we = in_hs &&
        (((state == ST_HEADER) && hdr_ok) ||
         ((state == ST_STORE) && !oversize));

    handler_pkt_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clock (clock),
        .we    (we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata ({axis_in_tlast, axis_in_tdata}),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rdata)
    );

    // Only the committed region is visible downstream.
    assign axis_handler_tvalid = (rd_ptr != commit_ptr);
    assign axis_handler_tdata  = rdata[WORD_W-1:0];
    assign axis_handler_tlast  = rdata[WORD_W];

    // Filter FSM with write/commit/read pointers and drop counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_HEADER;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            pkt_len    <= '0;
            drop_count <= '0;
        end else begin
            if (out_hs) rd_ptr <= rd_ptr + 1'b1;
            if (in_hs) begin
                unique case (state)
                    ST_HEADER: begin
                        if (hdr_ok) begin
                            wr_ptr <= wr_ptr + 1'b1;
                            if (axis_in_tlast) begin
                                commit_ptr <= wr_ptr + 1'b1;
                                pkt_len    <= '0;
                            end else begin
                                pkt_len <= PW'(1);
                                state   <= ST_STORE;
                            end
                        end else begin
                            drop_count <= sat_inc16(drop_count);
                            if (!axis_in_tlast) state <= ST_DROP;
                        end
                    end
                    ST_STORE: begin
                        if (oversize) begin
                            wr_ptr     <= commit_ptr;
                            pkt_len    <= '0;
                            drop_count <= sat_inc16(drop_count);
                            state <= axis_in_tlast ? ST_HEADER : ST_DROP;
                        end else if (axis_in_tlast) begin
                            wr_ptr     <= wr_ptr + 1'b1;
                            commit_ptr <= wr_ptr + 1'b1;
                            pkt_len    <= '0;
                            state      <= ST_HEADER;
                        end else begin
                            wr_ptr  <= wr_ptr + 1'b1;
                            pkt_len <= pkt_len + 1'b1;
                        end
                    end
                    ST_DROP: begin
                        if (axis_in_tlast) state <= ST_HEADER;
                    end
                    default: state <= ST_HEADER;
                endcase
            end
        end
    end

endmodule
